// File: rtl/trig_capture.sv
// rtl/trig_capture.sv - trigger-based sample capture into a circular RAM window
//
// Samples din into a DEPTH-entry circular RAM on every clken strobe while armed.
// After PRE_DEPTH pre-trigger samples it waits for a level crossing (or
// force_trig), then captures the rest of the window and freezes. The window is
// read back in trigger-aligned order: rd_addr 0 is the oldest sample and the
// trigger sample sits at rd_addr PRE_DEPTH.
//
// Ports:
//   clk_50M     in   system clock
//   rst         in   synchronous active-high reset
//   clken       in   sample strobe
//   din         in   [DW-1:0] sample data (unsigned)
//   arm         in   one-cycle pulse, starts/restarts a capture
//   force_trig  in   forces a trigger on the next sample in WAIT_TRIG
//   trig_level  in   [DW-1:0] trigger threshold (unsigned)
//   trig_fall   in   0 = rising crossing, 1 = falling crossing
//   rd_addr     in   [AW-1:0] logical read index
//   rd_data     out  [DW-1:0] registered read data, 1-cycle latency
//   busy        out  capture in progress (PRE, WAIT_TRIG, POST)
//   triggered   out  trigger seen since last arm
//   done        out  window frozen and valid
module trig_capture #(
  parameter int DW        = 8,
  parameter int AW        = 10,
  parameter int PRE_DEPTH = 256
) (
  input  logic          clk_50M,
  input  logic          rst,
  input  logic          clken,
  input  logic [DW-1:0] din,
  input  logic          arm,
  input  logic          force_trig,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_fall,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          triggered,
  output logic          done
);

  localparam int DEPTH    = 1 << AW;
  localparam int POST_LEN = DEPTH - PRE_DEPTH - 1;

  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_DEPTH);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_DEPTH - 1);
  // Unused when POST_LEN is 0: the trigger sample then completes the window.
  localparam logic [AW-1:0] POST_LAST = AW'(POST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] start_ptr_q, start_ptr_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic          busy_q, busy_d;
  logic          triggered_q, triggered_d;
  logic          done_q, done_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic [DW-1:0] mem [DEPTH];

  logic          capturing;
  logic          mem_we;
  logic          trig_rise;
  logic          trig_fall_hit;
  logic          trig_hit;
  logic [AW-1:0] rd_idx;

  always_comb begin
    capturing     = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    trig_rise     = prev_valid_q && !trig_fall && (prev_q < trig_level) && (din >= trig_level);
    trig_fall_hit = prev_valid_q &&  trig_fall && (prev_q > trig_level) && (din <= trig_level);
    trig_hit      = force_trig || trig_rise || trig_fall_hit;
    rd_idx        = start_ptr_q + rd_addr;
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    start_ptr_d  = start_ptr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    triggered_d  = triggered_q;
    mem_we       = 1'b0;

    if (arm) begin
      // arm takes priority over a coincident strobe; that sample is dropped.
      state_d      = S_PRE;
      cnt_d        = '0;
      prev_valid_d = 1'b0;
      triggered_d  = 1'b0;
    end else if (clken && capturing) begin
      mem_we       = !rst;
      wr_ptr_d     = wr_ptr_q + ONE;
      prev_d       = din;
      prev_valid_d = 1'b1;
      case (state_q)
        S_PRE: begin
          if (cnt_q == PRE_LAST) begin
            state_d = S_WAIT_TRIG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        S_WAIT_TRIG: begin
          if (trig_hit) begin
            // wr_ptr_q is where the trigger sample lands; the window starts
            // PRE_DEPTH entries behind it, which the free-running circular
            // writes have kept intact.
            start_ptr_d = wr_ptr_q - PRE_OFS;
            triggered_d = 1'b1;
            cnt_d       = '0;
            state_d     = (POST_LEN == 0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (cnt_q == POST_LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
        end
      endcase
    end

    busy_d    = (state_d == S_PRE) || (state_d == S_WAIT_TRIG) || (state_d == S_POST);
    done_d    = (state_d == S_DONE);
    rd_data_d = mem[rd_idx];
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      start_ptr_q  <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      start_ptr_q  <= start_ptr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      busy_q       <= busy_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Sample RAM: contents survive reset; write enable already excludes reset.
  always_ff @(posedge clk_50M) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;

endmodule

// File: tb/tb_trig_capture.sv
// tb/tb_trig_capture.sv - self-checking bench for trig_capture (AW=4, PRE_DEPTH=4)
module tb_trig_capture;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int PD = 4;

  logic          clk_50M = 1'b0;
  logic          rst;
  logic          clken;
  logic [DW-1:0] din;
  logic          arm;
  logic          force_trig;
  logic [DW-1:0] trig_level;
  logic          trig_fall;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          triggered;
  logic          done;

  trig_capture #(.DW(DW), .AW(AW), .PRE_DEPTH(PD)) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .clken      (clken),
    .din        (din),
    .arm        (arm),
    .force_trig (force_trig),
    .trig_level (trig_level),
    .trig_fall  (trig_fall),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );

  always #10 clk_50M = ~clk_50M;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] sb_q[$];

  typedef struct {
    logic          fall;
    logic [DW-1:0] level;
    logic [DW-1:0] start;
    int            step;
    int            period;
    int            exp_writes;
    logic [DW-1:0] exp_first;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic sample(input logic [DW-1:0] v);
    clken = 1'b1;
    din   = v;
    tick();
    clken = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Expected words are queued as each address is presented and popped one
  // cycle later, while the next address is already on rd_addr.
  task automatic read_window(input string name, input logic [DW-1:0] first, input int stp);
    logic [DW-1:0] exp;
    clken = 1'b0;
    for (int a = 0; a <= 16; a++) begin
      if (a < 16) begin
        rd_addr = AW'(a);
        sb_q.push_back(DW'(int'(first) + a * stp));
      end
      #2;
      if (a > 0) begin
        exp = sb_q.pop_front();
        check($sformatf("%s_rd[%0d]", name, a - 1), rd_data, exp);
      end
      tick();
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int            writes;
    int            cyc;
    logic [DW-1:0] val;
    writes     = 0;
    cyc        = 0;
    val        = v.start;
    trig_fall  = v.fall;
    trig_level = v.level;
    force_trig = 1'b0;
    clken      = 1'b0;
    pulse_arm();
    check($sformatf("v%0d_busy_after_arm", idx), busy, 1);
    check($sformatf("v%0d_trig_after_arm", idx), triggered, 0);
    while (!done && cyc < 400) begin
      if (cyc % v.period == v.period - 1) begin
        clken = 1'b1;
        din   = val;
      end else begin
        clken = 1'b0;
      end
      tick();
      if (clken) begin
        writes++;
        val = DW'(int'(val) + v.step);
        if (writes == v.exp_writes - 1) begin
          check($sformatf("v%0d_busy_before_last", idx), {busy, done}, 2'b10);
        end
      end
      cyc++;
    end
    clken = 1'b0;
    check($sformatf("v%0d_done", idx), done, 1);
    check($sformatf("v%0d_writes_to_done", idx), writes, v.exp_writes);
    check($sformatf("v%0d_busy_at_done", idx), busy, 0);
    check($sformatf("v%0d_triggered", idx), triggered, 1);
    read_window($sformatf("v%0d", idx), v.exp_first, v.step);
  endtask

  initial begin
    // rising ramp; falling sparse ramp; rising step-3 ramp after pointer wrap
    vecs[0] = '{1'b0, 8'd10,  8'd0,    1, 1, 22, 8'd6};
    vecs[1] = '{1'b1, 8'd200, 8'd204, -1, 5, 16, 8'd204};
    vecs[2] = '{1'b0, 8'h80,  8'h70,   3, 2, 18, 8'h76};

    rst        = 1'b1;
    clken      = 1'b0;
    din        = '0;
    arm        = 1'b0;
    force_trig = 1'b0;
    trig_level = '0;
    trig_fall  = 1'b0;
    rd_addr    = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_triggered", triggered, 0);
    check("rst_done", done, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      run_vec(vecs[i], i);
    end

    // crossing at the 2nd PRE sample must be ignored
    trig_fall  = 1'b0;
    trig_level = 8'd10;
    pulse_arm();
    sample(8'd5);
    sample(8'd12);
    sample(8'd12);
    sample(8'd12);
    for (int i = 0; i < 10; i++) sample(8'd12);
    check("premask_triggered", triggered, 0);
    check("premask_done", done, 0);
    check("premask_busy", busy, 1);
    sample(8'd5);
    sample(8'd10);
    check("premask_late_cross", triggered, 1);

    // force_trig on constant data
    pulse_arm();
    for (int i = 0; i < PD; i++) sample(8'h55);
    check("force_not_yet", triggered, 0);
    force_trig = 1'b1;
    sample(8'h55);
    force_trig = 1'b0;
    check("force_triggered", triggered, 1);
    for (int i = 0; i < 10; i++) sample(8'h55);
    check("force_done_early", done, 0);
    sample(8'h55);
    check("force_done", done, 1);
    read_window("force", 8'h55, 0);

    // arm mid-POST; the coincident strobe carries 0xAA and must be dropped
    pulse_arm();
    for (int i = 0; i < PD; i++) sample(8'h55);
    force_trig = 1'b1;
    sample(8'h55);
    force_trig = 1'b0;
    sample(8'h55);
    sample(8'h55);
    check("midpost_triggered", triggered, 1);
    clken = 1'b1;
    din   = 8'hAA;
    pulse_arm();
    clken = 1'b0;
    check("rearm_triggered", triggered, 0);
    check("rearm_busy", busy, 1);
    check("rearm_done", done, 0);

    // reset during POST, then strobes in IDLE must not write
    for (int i = 0; i < PD; i++) sample(8'h55);
    force_trig = 1'b1;
    sample(8'h55);
    force_trig = 1'b0;
    sample(8'h55);
    sample(8'h55);
    rd_addr = 4'd3;
    clken   = 1'b1;
    din     = 8'hAA;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_triggered", triggered, 0);
    check("midrst_done", done, 0);
    check("midrst_rd_data", rd_data, 0);
    for (int i = 0; i < 20; i++) sample(8'hAA);
    check("idle_busy", busy, 0);
    read_window("post_rst", 8'h55, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
